// File: rtl/counter_down_reload.sv
// -----------------------------------------------------------------------------
// counter_down_reload
//   Cascadable loadable down-counter / timer. Counts from a loaded value down
//   to zero. It then either reloads the value and keeps going (periodic tick)
//   or stops (one-shot). The borrow-out Bc chains into the borrow-in of the
//   next stage. The upper stage therefore decrements once per wrap of the
//   lower stage.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   load   in   1      synchronous load strobe; captures din and mode
//   din    in   WIDTH  load value (0 means "stay idle")
//   mode   in   1      0 = one-shot, 1 = auto-reload; sampled only on load
//   en     in   1      count enable
//   bin    in   1      borrow-in; tie 1 on a standalone / lowest stage
//   Q      out  WIDTH  current count, registered
//   Bc     out  1      borrow-out, combinational (terminal tick of this stage)
//   busy   out  1      high while counting (RUN state)
//   done   out  1      one-cycle pulse after each terminal tick
// -----------------------------------------------------------------------------
module counter_down_reload #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    input  logic             en,
    input  logic             bin,
    output logic [WIDTH-1:0] Q,
    output logic             Bc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic             tick;
    logic             at_zero;

    // A tick only exists while running, and only when both the local enable
    // and the borrow from the stage below are present.
    assign tick    = (state_q == S_RUN) && en && bin;
    assign at_zero = (q_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;

        if (load) begin
            // Load overrides everything, including a terminal tick in the
            // same cycle. That cycle produces no done pulse.
            q_d      = din;
            reload_d = din;
            mode_d   = mode;
            state_d  = (din != '0) ? S_RUN : S_IDLE;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (tick) begin
                        if (!at_zero) begin
                            q_d = q_q - WIDTH'(1);
                        end else begin
                            // Terminal tick: Q==0 never decrements, so no
                            // underflow is possible.
                            done_d = 1'b1;
                            if (mode_q) begin
                                q_d = reload_q;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        Q    = q_q;
        busy = (state_q == S_RUN);
        done = done_q;
        // A load in the same cycle cancels the terminal tick, so the borrow
        // is cancelled as well.
        Bc   = tick && at_zero && !load;
    end

endmodule
